// File: rtl/uart_tx_frame.sv
// uart_tx_frame: sends a 32-bit word as a 6-byte 8N1 UART packet STX, d[7:0]..d[31:24], ETX
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   tx_start      one-cycle request, data_in valid in the same cycle
//   data_in       word to send (RAM read word)
//   tx            registered serial line, idle high
//   busy          high while a frame is on the line
//   done          one-cycle pulse after the last ETX stop-bit cycle
//   overrun       one-cycle pulse when a request is dropped
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 2604,
  parameter logic [7:0] STX = 8'h02,
  parameter logic [7:0] ETX = 8'h03
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_start,
  input  logic [31:0] data_in,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic        overrun
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [BW-1:0] baud_cnt, baud_n;
  logic [2:0] bit_cnt, bit_n, byte_cnt, byte_n;
  logic [47:0] shift, shift_n;
  logic bit_end, accept, tx_n;
  // tx, busy and done are registered from the current state, so the line
  // trails the FSM by one cycle and busy stays high through the ETX stop bit.
  always_comb begin
    bit_end = baud_cnt == BW'(CLKS_PER_BIT - 1);
    accept = tx_start && !busy && state == IDLE;
    state_n = state;
    baud_n = (state == IDLE || bit_end) ? '0 : baud_cnt + 1'b1;
    bit_n = bit_cnt;
    byte_n = byte_cnt;
    shift_n = shift;
    tx_n = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
    case (state)
      IDLE: if (accept) begin
        state_n = START;
        shift_n = {ETX, data_in, STX};
        bit_n = '0;
        byte_n = '0;
      end
      START: if (bit_end) state_n = DATA;
      DATA: if (bit_end) begin
        shift_n = shift >> 1;
        bit_n = bit_cnt + 1'b1;
        state_n = bit_cnt == 3'd7 ? STOP : DATA;
      end
      STOP: if (bit_end) begin
        state_n = byte_cnt == 3'd5 ? IDLE : START;
        byte_n = byte_cnt == 3'd5 ? 3'd0 : byte_cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      baud_cnt <= '0;
      bit_cnt <= '0;
      byte_cnt <= '0;
      shift <= '0;
      tx <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      baud_cnt <= baud_n;
      bit_cnt <= bit_n;
      byte_cnt <= byte_n;
      shift <= shift_n;
      tx <= tx_n;
      busy <= state != IDLE;
      // busy still high while the FSM already sits in IDLE marks the frame end
      done <= state == IDLE && busy;
      overrun <= tx_start && !accept;
    end
  end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed checks of framing, timing, overrun, back-to-back and reset
module tb_uart_tx_frame;
  localparam int C = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_start = 1'b0;
  logic [31:0] data_in = '0;
  logic tx, busy, done, overrun;
  int vectors = 0;
  int miscompares = 0;
  logic samp [0:399];
  logic bsamp [0:399];
  int busy_n, done_n, done_p, ovr_n, zero_p;

  uart_tx_frame #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .data_in(data_in),
    .tx(tx), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Records the line for len cycles after a request driven just before the call.
  // Sample p is taken after edge N+p-1, where edge N accepts the request.
  task automatic capture(input int len, input logic [31:0] after_data, input int pulse_at,
                         input logic [31:0] pulse_data, input int rst_at);
    busy_n = 0; done_n = 0; done_p = -1; ovr_n = 0; zero_p = -1;
    for (int p = 1; p <= len; p++) begin
      @(negedge clk);
      samp[p] = tx;
      bsamp[p] = busy;
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) begin
        done_n++;
        if (done_p < 0) done_p = p;
      end
      if (overrun === 1'b1) ovr_n++;
      if (tx === 1'b0 && zero_p < 0) zero_p = p;
      tx_start = (p == pulse_at);
      data_in = (p == pulse_at) ? pulse_data : after_data;
      rst = (p == rst_at);
    end
  endtask

  // Byte k as seen on the line: bit 0 start, bits 8:1 data, bit 9 stop, sampled mid-bit.
  function automatic logic [9:0] line_byte(input int k);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = samp[C * (10 * k + i) + 3];
    return r;
  endfunction

  function automatic logic [9:0] exp_byte(input logic [31:0] d, input int k);
    logic [7:0] b;
    b = k == 0 ? 8'h02 : k == 5 ? 8'h03 : d[8 * (k - 1) +: 8];
    return {1'b1, b, 1'b0};
  endfunction

  task automatic test_reset();
    int z;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx got %b want 1", tx); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun got %b want 0", overrun); end
    z = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) z++;
    end
    vectors++; if (z != 0) begin miscompares++; $display("FAIL idle_tx low_cycles got %0d want 0", z); end
  endtask

  task automatic test_single();
    data_in = 32'h12345678; tx_start = 1'b1;
    capture(260, 32'h12345678, -1, '0, -1);
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (line_byte(k) !== exp_byte(32'h12345678, k)) begin
        miscompares++; $display("FAIL single byte%0d got %h want %h", k, line_byte(k), exp_byte(32'h12345678, k));
      end
    end
    vectors++; if (samp[1] !== 1'b1) begin miscompares++; $display("FAIL single tx_in_accept_cycle got %b want 1", samp[1]); end
    vectors++; if (zero_p != 2) begin miscompares++; $display("FAIL single first_zero got %0d want 2", zero_p); end
    vectors++; if (done_p != 242) begin miscompares++; $display("FAIL single done_at got %0d want 242", done_p); end
    vectors++; if (done_n != 1) begin miscompares++; $display("FAIL single done_count got %0d want 1", done_n); end
    vectors++; if (busy_n != 240) begin miscompares++; $display("FAIL single busy_cycles got %0d want 240", busy_n); end
    vectors++; if (bsamp[242] !== 1'b0) begin miscompares++; $display("FAIL single busy_in_done got %b want 0", bsamp[242]); end
    vectors++; if (ovr_n != 0) begin miscompares++; $display("FAIL single overrun got %0d want 0", ovr_n); end
  endtask

  task automatic test_isolation();
    data_in = 32'hA5A5A5A5; tx_start = 1'b1;
    capture(250, 32'hFFFFFFFF, -1, '0, -1);
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (line_byte(k) !== exp_byte(32'hA5A5A5A5, k)) begin
        miscompares++; $display("FAIL isolation byte%0d got %h want %h", k, line_byte(k), exp_byte(32'hA5A5A5A5, k));
      end
    end
  endtask

  task automatic test_overrun();
    int z;
    data_in = 32'h00000001; tx_start = 1'b1;
    capture(300, 32'h0, 50, 32'hDEADBEEF, -1);
    vectors++; if (ovr_n != 1) begin miscompares++; $display("FAIL overrun pulses got %0d want 1", ovr_n); end
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (line_byte(k) !== exp_byte(32'h00000001, k)) begin
        miscompares++; $display("FAIL overrun byte%0d got %h want %h", k, line_byte(k), exp_byte(32'h00000001, k));
      end
    end
    z = 0;
    for (int p = 243; p <= 300; p++) if (samp[p] !== 1'b1) z++;
    vectors++; if (z != 0) begin miscompares++; $display("FAIL overrun idle_after low_cycles got %0d want 0", z); end
    vectors++; if (busy_n != 240) begin miscompares++; $display("FAIL overrun busy_cycles got %0d want 240", busy_n); end
    vectors++; if (done_n != 1) begin miscompares++; $display("FAIL overrun done_count got %0d want 1", done_n); end
  endtask

  task automatic test_back_to_back();
    data_in = 32'h12345678; tx_start = 1'b1;
    capture(242, 32'h12345678, -1, '0, -1);
    vectors++; if (done_p != 242) begin miscompares++; $display("FAIL b2b first_done_at got %0d want 242", done_p); end
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (line_byte(k) !== exp_byte(32'h12345678, k)) begin
        miscompares++; $display("FAIL b2b first byte%0d got %h want %h", k, line_byte(k), exp_byte(32'h12345678, k));
      end
    end
    data_in = 32'h0BADF00D; tx_start = 1'b1;
    capture(250, 32'h0BADF00D, -1, '0, -1);
    vectors++; if (zero_p != 2) begin miscompares++; $display("FAIL b2b second_first_zero got %0d want 2", zero_p); end
    vectors++; if (ovr_n != 0) begin miscompares++; $display("FAIL b2b overrun got %0d want 0", ovr_n); end
    vectors++; if (done_n != 1) begin miscompares++; $display("FAIL b2b second_done_count got %0d want 1", done_n); end
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (line_byte(k) !== exp_byte(32'h0BADF00D, k)) begin
        miscompares++; $display("FAIL b2b second byte%0d got %h want %h", k, line_byte(k), exp_byte(32'h0BADF00D, k));
      end
    end
  endtask

  task automatic test_reset_mid();
    data_in = 32'h12345678; tx_start = 1'b1;
    capture(260, 32'h12345678, -1, '0, 100);
    vectors++; if (samp[101] !== 1'b1) begin miscompares++; $display("FAIL midreset tx got %b want 1", samp[101]); end
    vectors++; if (bsamp[101] !== 1'b0) begin miscompares++; $display("FAIL midreset busy got %b want 0", bsamp[101]); end
    vectors++; if (done_n != 0) begin miscompares++; $display("FAIL midreset done_count got %0d want 0", done_n); end
    data_in = 32'h0BADF00D; tx_start = 1'b1;
    capture(250, 32'h0BADF00D, -1, '0, -1);
    vectors++; if (done_n != 1) begin miscompares++; $display("FAIL midreset next_done_count got %0d want 1", done_n); end
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (line_byte(k) !== exp_byte(32'h0BADF00D, k)) begin
        miscompares++; $display("FAIL midreset next byte%0d got %h want %h", k, line_byte(k), exp_byte(32'h0BADF00D, k));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_isolation();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
